// File: rtl/waka_recorder.sv
// waka_recorder: counts level transitions on each toggle-encoded line over one
// frame window, decodes the count to an 8-bit pixel and drains one byte per
// row into picture memory over a valid/ready write port.
module waka_recorder #(
  parameter int                LINES      = 8,
  parameter int                THIN       = 3,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] HEAD       = 16'h0100,
  parameter int                PIC_W_BYTE = 64,
  parameter int                COL_STEP   = 3
) (
  input  logic              clk,
  input  logic              rst_N,
  input  logic              frame_sync,
  input  logic [LINES-1:0]  picin,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              overrun,
  output logic [7:0]        frame_cnt
);

  localparam int                LI_W    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [LI_W-1:0]   LI_LAST = LI_W'(LINES - 1);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(PIC_W_BYTE);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(COL_STEP);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Transition count back to brightness; the product is kept wide so large
  // counts saturate instead of wrapping.
  function automatic logic [7:0] decode(input logic [8:0] cnt);
    logic [31:0] prod;
    prod = {23'd0, cnt} * 32'(THIN + 1);
    if (prod > 32'd255) begin
      decode = 8'hFF;
    end else begin
      decode = prod[7:0];
    end
  endfunction

  // Memory address of a row within a picture column; wraps at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [LI_W-1:0] li,
                                                 input logic [ADDR_W-1:0] col);
    row_addr = HEAD + ADDR_W'(li) * STRIDE + col;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [LINES-1:0]  r_prev;
  logic [8:0]        r_tcnt [LINES];
  logic [7:0]        r_bank [LINES];
  logic [7:0]        w_bank_nxt [LINES];
  logic              r_bank_full, w_full_nxt;
  logic [ADDR_W-1:0] r_bcol, w_bcol_nxt;
  logic [ADDR_W-1:0] r_fcol, w_fcol_nxt;
  logic [LI_W-1:0]   r_li, w_li_nxt, w_li_inc;
  logic [ADDR_W-1:0] r_wr_addr, w_addr_nxt;
  logic [7:0]        r_wr_data, w_data_nxt;
  logic              r_overrun, w_ovr_nxt;
  logic [7:0]        r_frame_cnt, w_fcnt_nxt;
  logic              w_hs, w_last, w_capture, w_drop;

  // The bank is only full while a drain is in progress, so it doubles as wr_valid.
  assign wr_valid  = r_bank_full;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign overrun   = r_overrun;
  assign frame_cnt = r_frame_cnt;

  assign w_hs     = r_bank_full & wr_ready;
  assign w_last   = (r_li == LI_LAST);
  assign w_li_inc = r_li + LI_W'(1);

  // Per-line edge detection and saturating transition count; sync restarts the window with the line low.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_prev <= '0;
      for (int i = 0; i < LINES; i++) r_tcnt[i] <= 9'd0;
    end else if (frame_sync) begin
      r_prev <= '0;
      for (int i = 0; i < LINES; i++) r_tcnt[i] <= 9'd0;
    end else begin
      r_prev <= picin;
      for (int i = 0; i < LINES; i++) begin
        if ((picin[i] != r_prev[i]) && (r_tcnt[i] != 9'h1FF)) begin
          r_tcnt[i] <= r_tcnt[i] + 9'd1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath logic: capture, drain advance and frame drop.
  always_comb begin
    w_state_nxt = r_state;
    w_bank_nxt  = r_bank;
    w_full_nxt  = r_bank_full;
    w_bcol_nxt  = r_bcol;
    w_fcol_nxt  = r_fcol;
    w_li_nxt    = r_li;
    w_addr_nxt  = r_wr_addr;
    w_data_nxt  = r_wr_data;
    w_ovr_nxt   = r_overrun;
    w_fcnt_nxt  = r_frame_cnt;
    w_capture   = 1'b0;
    w_drop      = 1'b0;

    case (r_state)
      ST_ARM: begin
        // The window before the first sync is partial and is thrown away.
        if (frame_sync) begin
          w_state_nxt = ST_IDLE;
          w_fcol_nxt  = '0;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (frame_sync) begin
          w_capture = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_hs && w_last) begin
          // A sync landing on the final handshake is a clean back-to-back capture.
          if (frame_sync) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_full_nxt  = 1'b0;
          end
        end else if (w_hs) begin
          w_li_nxt   = w_li_inc;
          w_addr_nxt = row_addr(w_li_inc, r_bcol);
          w_data_nxt = r_bank[w_li_inc];
          w_drop     = frame_sync;
        end else begin
          w_drop = frame_sync;
        end
      end
      default: begin
        w_state_nxt = ST_ARM;
        w_full_nxt  = 1'b0;
      end
    endcase

    if (w_capture) begin
      for (int i = 0; i < LINES; i++) w_bank_nxt[i] = decode(r_tcnt[i]);
      w_full_nxt  = 1'b1;
      w_bcol_nxt  = r_fcol;
      w_fcol_nxt  = r_fcol + STEP;
      w_li_nxt    = LI_W'(0);
      w_addr_nxt  = row_addr(LI_W'(0), r_fcol);
      w_data_nxt  = decode(r_tcnt[0]);
      w_fcnt_nxt  = r_frame_cnt + 8'd1;
      w_state_nxt = ST_DRAIN;
    end else if (w_drop) begin
      // The previous picture is still draining: skip this frame's column.
      w_ovr_nxt  = 1'b1;
      w_fcol_nxt = r_fcol + STEP;
      w_fcnt_nxt = r_frame_cnt + 8'd1;
    end else begin
      w_ovr_nxt = r_overrun;
    end
  end

  // Datapath registers: result bank, columns, drain index and write port.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      for (int i = 0; i < LINES; i++) r_bank[i] <= 8'd0;
      r_bank_full <= 1'b0;
      r_bcol      <= '0;
      r_fcol      <= '0;
      r_li        <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      for (int i = 0; i < LINES; i++) r_bank[i] <= w_bank_nxt[i];
      r_bank_full <= w_full_nxt;
      r_bcol      <= w_bcol_nxt;
      r_fcol      <= w_fcol_nxt;
      r_li        <= w_li_nxt;
      r_wr_addr   <= w_addr_nxt;
      r_wr_data   <= w_data_nxt;
      r_overrun   <= w_ovr_nxt;
      r_frame_cnt <= w_fcnt_nxt;
    end
  end

endmodule

// File: tb/tb_waka_recorder.sv
// Self-checking bench for waka_recorder: a table of single-row decode vectors,
// randomized frames against a queue-based reference model, and hand-written
// backpressure / overrun / boundary / reset sequences.
module tb_waka_recorder;

  localparam int LINES = 8;

  logic             clk = 1'b0;
  logic             rst_N = 1'b0;
  logic             frame_sync = 1'b0;
  logic [LINES-1:0] picin = '0;
  logic             wr_ready = 1'b0;
  logic             wr_valid;
  logic [15:0]      wr_addr;
  logic [7:0]       wr_data;
  logic             overrun;
  logic [7:0]       frame_cnt;

  waka_recorder dut (
    .clk        (clk),
    .rst_N      (rst_N),
    .frame_sync (frame_sync),
    .picin      (picin),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected writes of the current picture in a queue.
  typedef struct {
    int          row;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         m_q[$];
  bit          m_armed;
  bit          m_ovr;
  int          m_fcnt;
  int          m_fcol;
  int          m_cnt  [LINES];
  bit          m_prev [LINES];
  logic [15:0] obs_addr [LINES];
  logic [7:0]  obs_data [LINES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int cnt);
    int c;
    c = (cnt > 511) ? 511 : cnt;
    c = c * 4;
    return (c > 255) ? 8'd255 : 8'(c);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_armed = 1'b0;
    m_ovr   = 1'b0;
    m_fcnt  = 0;
    m_fcol  = 0;
    for (int i = 0; i < LINES; i++) begin
      m_cnt[i]  = 0;
      m_prev[i] = 1'b0;
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < LINES; i++) begin
      obs_addr[i] = 16'hDEAD;
      obs_data[i] = 8'hA5;
    end
  endtask

  // One clock: check outputs of the last edge, drive inputs, advance the model.
  task automatic step(input bit s, input logic [LINES-1:0] p, input bit r);
    wr_t w;
    @(negedge clk);
    chk("wr_valid", wr_valid, (m_q.size() != 0));
    chk("overrun", overrun, m_ovr);
    chk("frame_cnt", frame_cnt, m_fcnt % 256);
    if (m_q.size() != 0) begin
      chk("wr_addr", wr_addr, m_q[0].addr);
      chk("wr_data", wr_data, m_q[0].data);
    end
    frame_sync = s;
    picin      = p;
    wr_ready   = r;
    if ((m_q.size() != 0) && r) begin
      w = m_q.pop_front();
      obs_addr[w.row] = wr_addr;
      obs_data[w.row] = wr_data;
    end
    if (s) begin
      if (!m_armed) begin
        m_armed = 1'b1;
        m_fcol  = 0;
      end else if (m_q.size() == 0) begin
        for (int i = 0; i < LINES; i++) begin
          w.row  = i;
          w.addr = 16'((32'h0100 + i * 64 + m_fcol) % 65536);
          w.data = pix(m_cnt[i]);
          m_q.push_back(w);
        end
        m_fcol = (m_fcol + 3) % 65536;
        m_fcnt++;
      end else begin
        m_ovr  = 1'b1;
        m_fcol = (m_fcol + 3) % 65536;
        m_fcnt++;
      end
      for (int i = 0; i < LINES; i++) begin
        m_cnt[i]  = 0;
        m_prev[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < LINES; i++) begin
        if (p[i] != m_prev[i]) m_cnt[i]++;
        m_prev[i] = p[i];
      end
    end
  endtask

  // Look at outputs just after the edge that consumed the last step's inputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_N      = 1'b0;
    frame_sync = 1'b0;
    wr_ready   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      picin = LINES'($urandom);
      @(negedge clk);
    end
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    model_reset();
    picin = '0;
    @(negedge clk);
    rst_N = 1'b1;
  endtask

  // 255 cycles of a window with row toggling n times, then the sync cycle.
  task automatic run_window(input int row, input int n, input bit stog, input bit rdy);
    logic [LINES-1:0] p;
    bit lvl;
    for (int c = 0; c < 255; c++) begin
      p = '0;
      lvl = (c < n) ? bit'((c + 1) & 1) : bit'(n & 1);
      p[row] = lvl;
      step(1'b0, p, rdy);
    end
    p = '0;
    p[row] = stog ? ~bit'(n & 1) : bit'(n & 1);
    step(1'b1, p, rdy);
  endtask

  typedef struct {
    int          row;
    int          n;
    bit          stog;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] a0;
  logic [7:0]  d0;
  logic [LINES-1:0] alt;

  initial begin
    vecs[0] = '{2, 10, 1'b0, 16'h0180, 8'd40};
    vecs[1] = '{0, 70, 1'b1, 16'h0100, 8'd255};
    vecs[2] = '{1, 63, 1'b1, 16'h0140, 8'd252};
    vecs[3] = '{7, 1,  1'b0, 16'h02C0, 8'd4};
    vecs[4] = '{5, 64, 1'b1, 16'h0240, 8'd255};
    vecs[5] = '{4, 0,  1'b1, 16'h0200, 8'd0};
    model_reset();

    // Table: one row per frame after a fresh reset, so the column is 0.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      clear_obs();
      step(1'b1, '0, 1'b1);
      run_window(vecs[v].row, vecs[v].n, vecs[v].stog, 1'b1);
      for (int k = 0; k < LINES + 2; k++) step(1'b0, '0, 1'b1);
      chk("vec_addr", obs_addr[vecs[v].row], vecs[v].exp_addr);
      chk("vec_data", obs_data[vecs[v].row], vecs[v].exp_data);
      chk("vec_other_addr", obs_addr[(vecs[v].row + 3) % LINES],
          16'h0100 + 16'(((vecs[v].row + 3) % LINES) * 64));
      chk("vec_other_data", obs_data[(vecs[v].row + 3) % LINES], 0);
    end

    // Backpressure then overrun with column skip.
    do_reset();
    step(1'b1, '0, 1'b1);
    run_window(0, 5, 1'b0, 1'b0);
    settle();
    a0 = wr_addr;
    d0 = wr_data;
    chk("bp_first_addr", a0, 16'h0100);
    chk("bp_first_data", d0, 20);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, '0, 1'b0);
      chk("bp_hold_valid", wr_valid, 1);
      chk("bp_hold_addr", wr_addr, a0);
      chk("bp_hold_data", wr_data, d0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
    for (int k = 0; k < 255 - 24; k++) step(1'b0, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    settle();
    chk("ovr_set", overrun, 1);
    chk("ovr_fcnt", frame_cnt, 2);
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1);
    run_window(3, 2, 1'b0, 1'b1);
    settle();
    chk("skip_addr", wr_addr, 16'h0106);
    chk("skip_fcnt", frame_cnt, 3);
    chk("skip_ovr_sticky", overrun, 1);
    for (int k = 0; k < LINES + 2; k++) step(1'b0, '0, 1'b1);

    // Sync on the final handshake, then reset mid-drain.
    do_reset();
    step(1'b1, '0, 1'b1);
    run_window(6, 3, 1'b0, 1'b1);
    for (int k = 0; k < LINES - 1; k++) step(1'b0, '0, 1'b1);
    step(1'b1, '0, 1'b1);
    settle();
    chk("bnd_ovr", overrun, 0);
    chk("bnd_valid", wr_valid, 1);
    chk("bnd_addr", wr_addr, 16'h0103);
    chk("bnd_fcnt", frame_cnt, 2);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    rst_N = 1'b0;
    #1;
    chk("async_rst_valid", wr_valid, 0);
    do_reset();
    step(1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, LINES'($urandom), 1'b1);
    settle();
    chk("rearm_no_write", wr_valid, 0);

    // Randomized frames, some short enough to overrun.
    do_reset();
    step(1'b1, '0, 1'b1);
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : int'($urandom_range(9, 60));
      for (int c = 0; c < len; c++) step(1'b0, LINES'($urandom), ($urandom_range(0, 3) != 0));
      step(1'b1, LINES'($urandom), bit'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 3 * LINES; k++) step(1'b0, '0, 1'b1);

    // Long frame: every line toggles past the 9-bit counter range.
    alt = '0;
    for (int c = 0; c < 520; c++) begin
      alt = ~alt;
      step(1'b0, alt, 1'b1);
    end
    step(1'b1, '0, 1'b1);
    for (int k = 0; k < LINES + 2; k++) step(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
